// File: rtl/gain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gain_ctrl_pkg
// Purpose  : Shared constants and types for the multi-channel gain controller.
//            Holds the register map, the CTRL bit positions and the readback
//            field offset, plus the per-channel step direction type.
// Ports    : none (package)
// Revision : 1.0 - initial multi-channel release
// ============================================================================
package gain_ctrl_pkg;

  // Word addresses on the Avalon-MM slave
  localparam int ADDR_CTRL    = 0;
  localparam int ADDR_DIV     = 1;
  localparam int ADDR_SHADOW0 = 2;

  // CTRL register bit positions
  localparam int RAMP_EN = 0;
  localparam int APPLY   = 1;
  localparam int BUSY    = 2;

  // LSB of the current-output field in a SHADOW readback word
  localparam int READBACK_CUR_LSB = 16;

  // Direction a channel output moves on the next ramp tick
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_dir_e;

endpackage
`default_nettype wire

// File: rtl/gain_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : gain_ctrl_mc_if
// Purpose  : Avalon-MM slave bus bundle for the gain controller.
// Ports    : address    - word address (ADDR_W bits)
//            chipselect - slave select
//            write_n    - active-low write strobe
//            writedata  - 32-bit write data
//            readdata   - 32-bit read data, zero read latency
//            Modports: master (bus driver) and slave (the controller).
// Revision : 1.0 - initial multi-channel release
// ============================================================================
interface gain_ctrl_mc_if #(
  parameter int ADDR_W = 3
);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/gain_ramp_ch.sv
`default_nettype none
// ============================================================================
// Module   : gain_ramp_ch
// Purpose  : One gain channel. Holds the committed target and the current
//            output code. The output either copies the target (snap) or moves
//            one LSB toward it on each tick.
// Ports    : clk, reset_n - clock, asynchronous active-low reset
//            load         - commit load_val into the target register
//            load_val     - new target (the channel's shadow register)
//            tick         - ramp step strobe from the shared prescaler
//            snap         - copy target into output (ramping disabled)
//            out          - current gain code
//            ch_busy      - output differs from target
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module gain_ramp_ch
  import gain_ctrl_pkg::*;
#(
  parameter int          GAIN_W     = 5,
  parameter int unsigned RESET_GAIN = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [GAIN_W-1:0] load_val,
  input  logic              tick,
  input  logic              snap,
  output logic [GAIN_W-1:0] out,
  output logic              ch_busy
);

  logic [GAIN_W-1:0] r_target;
  logic [GAIN_W-1:0] r_out;
  step_dir_e         w_dir;

  // Direction is taken from the registered target, so a retarget that lands
  // on the same edge as a tick steps toward the old target for that one edge.
  always_comb begin
    w_dir = STEP_HOLD;
    if (r_out < r_target) begin
      w_dir = STEP_UP;
    end else if (r_out > r_target) begin
      w_dir = STEP_DOWN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_target <= GAIN_W'(RESET_GAIN);
      r_out    <= GAIN_W'(RESET_GAIN);
    end else begin
      if (load) begin
        r_target <= load_val;
      end
      if (snap) begin
        r_out <= r_target;
      end else if (tick) begin
        // Stepping stops at the target, so the unsigned code never wraps.
        case (w_dir)
          STEP_UP:   r_out <= r_out + GAIN_W'(1);
          STEP_DOWN: r_out <= r_out - GAIN_W'(1);
          default:   r_out <= r_out;
        endcase
      end
    end
  end

  assign out     = r_out;
  assign ch_busy = (w_dir != STEP_HOLD);

endmodule
`default_nettype wire

// File: rtl/gain_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : gain_ctrl_mc
// Purpose  : Multi-channel PGA gain controller. An Avalon-MM slave holds
//            per-channel shadow gains that commit atomically on an APPLY
//            write. Each channel output jumps to its target or slews one LSB
//            per prescaler tick. busy is high while any channel is unsettled;
//            done pulses for one cycle when busy falls.
// Ports    : clk, reset_n - clock, asynchronous active-low reset
//            bus          - Avalon-MM slave (address, chipselect, write_n,
//                           writedata, readdata with zero read latency)
//            out_port     - current codes, channel c at [c*GAIN_W +: GAIN_W]
//            busy         - any channel output differs from its target
//            done         - one-cycle pulse when busy falls
// Note     : the register map needs 2+NUM_CH <= 2**ADDR_W.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module gain_ctrl_mc
  import gain_ctrl_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          GAIN_W     = 5,
  parameter int          ADDR_W     = 3,
  parameter int          DIV_W      = 16,
  parameter int unsigned RESET_GAIN = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  gain_ctrl_mc_if.slave            bus,
  output logic [NUM_CH*GAIN_W-1:0] out_port,
  output logic                     busy,
  output logic                     done
);

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_div;
  logic w_apply;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_wr_ctrl = w_wr && (bus.address == ADDR_W'(ADDR_CTRL));
  assign w_wr_div  = w_wr && (bus.address == ADDR_W'(ADDR_DIV));
  assign w_apply   = w_wr_ctrl && bus.writedata[APPLY];

  // Only the low bits of writedata are stored anywhere.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // --------------------------------------------------------------------------
  // Control registers and shadows
  // --------------------------------------------------------------------------
  logic                          r_ramp_en;
  logic [DIV_W-1:0]              r_step_div;
  logic [NUM_CH-1:0][GAIN_W-1:0] r_shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_en  <= 1'b0;
      r_step_div <= DIV_W'(1);
    end else begin
      // The APPLY write carries RAMP_EN too, so mode and targets commit together.
      if (w_wr_ctrl) begin
        r_ramp_en <= bus.writedata[RAMP_EN];
      end
      if (w_wr_div) begin
        r_step_div <= bus.writedata[DIV_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_shadow[c] <= GAIN_W'(RESET_GAIN);
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && (bus.address == ADDR_W'(ADDR_SHADOW0 + c))) begin
          r_shadow[c] <= bus.writedata[GAIN_W-1:0];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ramp prescaler
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_presc_tc;
  logic             w_tick;

  // A divider of 0 behaves as 1 (tick every busy cycle).
  assign w_div_eff  = (r_step_div == '0) ? DIV_W'(1) : r_step_div;
  assign w_presc_tc = (r_presc == (w_div_eff - DIV_W'(1)));
  // A divider write restarts the count, so it also suppresses the tick that
  // the old count would have produced on that edge.
  assign w_tick     = busy && r_ramp_en && w_presc_tc && !w_wr_div;

  // Held at 0 while idle, so the first step lands exactly max(STEP_DIV,1)
  // cycles after busy rises. An APPLY during a ramp leaves it running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (!busy || w_wr_div || w_presc_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Channels
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0][GAIN_W-1:0] w_out;
  logic [NUM_CH-1:0]             w_ch_busy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gain_ramp_ch #(
      .GAIN_W     (GAIN_W),
      .RESET_GAIN (RESET_GAIN)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_apply),
      .load_val (r_shadow[c]),
      .tick     (w_tick),
      .snap     (!r_ramp_en),
      .out      (w_out[c]),
      .ch_busy  (w_ch_busy[c])
    );

    assign out_port[c*GAIN_W +: GAIN_W] = w_out[c];
  end

  // --------------------------------------------------------------------------
  // busy / done
  // --------------------------------------------------------------------------
  logic r_busy_q;

  // busy compares registered outputs against registered targets, so it rises
  // on the APPLY edge itself and falls on the edge of the final step.
  assign busy = |w_ch_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_q <= 1'b0;
    end else begin
      r_busy_q <= busy;
    end
  end

  assign done = r_busy_q & ~busy;

  // --------------------------------------------------------------------------
  // Read mux (combinational, zero latency)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.readdata = '0;
    if (bus.address == ADDR_W'(ADDR_CTRL)) begin
      bus.readdata[RAMP_EN] = r_ramp_en;
      bus.readdata[BUSY]    = busy;
    end else if (bus.address == ADDR_W'(ADDR_DIV)) begin
      bus.readdata[DIV_W-1:0] = r_step_div;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.address == ADDR_W'(ADDR_SHADOW0 + c)) begin
        bus.readdata[GAIN_W-1:0]                  = r_shadow[c];
        bus.readdata[READBACK_CUR_LSB +: GAIN_W]  = w_out[c];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gain_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_gain_ctrl_mc
// Purpose  : Self-checking bench for gain_ctrl_mc: a table of directed bus
//            vectors, hand-written multi-cycle sequences, and randomized bus
//            traffic checked against a behavioural model of the controller.
// Ports    : none
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tb_gain_ctrl_mc;

  localparam int NUM_CH = 2;
  localparam int GAIN_W = 5;
  localparam int ADDR_W = 3;
  localparam int DIV_W  = 16;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_CH*GAIN_W-1:0] out_port;
  logic                     busy;
  logic                     done;

  gain_ctrl_mc_if #(.ADDR_W(ADDR_W)) bus ();

  gain_ctrl_mc #(
    .NUM_CH     (NUM_CH),
    .GAIN_W     (GAIN_W),
    .ADDR_W     (ADDR_W),
    .DIV_W      (DIV_W),
    .RESET_GAIN (0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: per-channel target/output as integers, a ramp phase
  // counter, and the register file.
  // --------------------------------------------------------------------------
  int m_shadow [NUM_CH];
  int m_tgt    [NUM_CH];
  int m_out    [NUM_CH];
  int m_ramp;
  int m_div;
  int m_phase;
  bit m_done;

  function automatic bit m_unsettled();
    bit any = 0;
    for (int c = 0; c < NUM_CH; c++) if (m_out[c] != m_tgt[c]) any = 1;
    return any;
  endfunction

  function automatic int m_period();
    return (m_div == 0) ? 1 : m_div;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = 0; m_tgt[c] = 0; m_out[c] = 0;
    end
    m_ramp = 0; m_div = 1; m_phase = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit w, input int a, input logic [31:0] d);
    bit was_busy;
    bit div_write;
    bit at_step;
    was_busy  = m_unsettled();
    div_write = w && (a == 1);
    at_step   = m_ramp && was_busy && !div_write && (m_phase == m_period() - 1);
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_ramp == 0)                         m_out[c] = m_tgt[c];
      else if (at_step && m_out[c] < m_tgt[c]) m_out[c] = m_out[c] + 1;
      else if (at_step && m_out[c] > m_tgt[c]) m_out[c] = m_out[c] - 1;
    end
    if (!was_busy || div_write || m_phase == m_period() - 1) m_phase = 0;
    else m_phase = m_phase + 1;
    if (w && a == 0 && d[1]) for (int c = 0; c < NUM_CH; c++) m_tgt[c] = m_shadow[c];
    if (w && a == 0) m_ramp = int'(d[0]);
    if (w && a == 1) m_div = int'(d[15:0]);
    if (w && a >= 2 && a < 2 + NUM_CH) m_shadow[a-2] = int'(d[4:0]);
    m_done = was_busy && !m_unsettled();
  endtask

  function automatic logic [31:0] model_rd(input int a);
    logic [31:0] r = '0;
    if (a == 0) r = (32'(m_unsettled()) << 2) | 32'(m_ramp);
    else if (a == 1) r = 32'(m_div);
    else if (a >= 2 && a < 2 + NUM_CH) r = (32'(m_out[a-2]) << 16) | 32'(m_shadow[a-2]);
    return r;
  endfunction

  function automatic logic [31:0] model_port();
    logic [31:0] p = '0;
    for (int c = 0; c < NUM_CH; c++) p = p | (32'(m_out[c]) << (c * GAIN_W));
    return p;
  endfunction

  // One bus cycle: drive, check readdata before the edge, advance the model at
  // the edge, check outputs 1 time unit after it.
  task automatic step(input bit w, input int a, input logic [31:0] d, output logic [31:0] rd);
    bus.chipselect = 1'b1;
    bus.write_n    = !w;
    bus.address    = ADDR_W'(a);
    bus.writedata  = d;
    #1;
    rd = bus.readdata;
    check($sformatf("readdata@%0d", a), bus.readdata, model_rd(a));
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check("out_port", 32'(out_port), model_port());
    check("busy", 32'(busy), 32'(m_unsettled()));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [9:0]  exp_out;
    bit          exp_busy;
    bit          exp_done;
  } vec_t;

  vec_t vecs [18];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd;
    int busy_cnt, done_cnt, prev, guard;
    bit rose;

    vecs[0]  = '{0, 0, 32'h0,         32'h0,         10'h000, 0, 0};
    vecs[1]  = '{0, 1, 32'h0,         32'h1,         10'h000, 0, 0};
    vecs[2]  = '{0, 7, 32'h0,         32'h0,         10'h000, 0, 0};
    vecs[3]  = '{1, 7, 32'hFFFF_FFFF, 32'h0,         10'h000, 0, 0};
    vecs[4]  = '{1, 2, 32'h1F,        32'h0,         10'h000, 0, 0};
    vecs[5]  = '{1, 3, 32'h05,        32'h0,         10'h000, 0, 0};
    vecs[6]  = '{0, 2, 32'h0,         32'h1F,        10'h000, 0, 0};
    vecs[7]  = '{0, 3, 32'h0,         32'h05,        10'h000, 0, 0};
    vecs[8]  = '{1, 0, 32'h2,         32'h0,         10'h000, 1, 0};
    vecs[9]  = '{0, 0, 32'h0,         32'h4,         10'h0BF, 0, 1};
    vecs[10] = '{0, 0, 32'h0,         32'h0,         10'h0BF, 0, 0};
    vecs[11] = '{0, 2, 32'h0,         32'h001F_001F, 10'h0BF, 0, 0};
    vecs[12] = '{0, 3, 32'h0,         32'h0005_0005, 10'h0BF, 0, 0};
    vecs[13] = '{1, 0, 32'h2,         32'h0,         10'h0BF, 0, 0};
    vecs[14] = '{0, 0, 32'h0,         32'h0,         10'h0BF, 0, 0};
    vecs[15] = '{1, 0, 32'h1,         32'h0,         10'h0BF, 0, 0};
    vecs[16] = '{0, 0, 32'h0,         32'h1,         10'h0BF, 0, 0};
    vecs[17] = '{0, 1, 32'h0,         32'h1,         10'h0BF, 0, 0};

    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    model_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out_port", 32'(out_port), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    reset_n = 1'b1;

    // Directed vector table: register map, jump mode, idle corner cases
    for (int i = 0; i < 18; i++) begin
      bus.chipselect = 1'b1;
      bus.write_n    = !vecs[i].wr;
      bus.address    = ADDR_W'(vecs[i].addr);
      bus.writedata  = vecs[i].data;
      #1;
      check($sformatf("vec%0d_readdata", i), bus.readdata, vecs[i].exp_rd);
      @(posedge clk);
      model_edge(vecs[i].wr, vecs[i].addr, vecs[i].data);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      check($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
    end

    // Ramp 0 -> 3 with STEP_DIV = 4
    do_reset();
    step(1, 1, 32'd4, rd);
    step(1, 2, 32'd3, rd);
    step(1, 0, 32'h3, rd);
    busy_cnt = int'(busy);
    done_cnt = int'(done);
    for (int i = 1; i <= 20; i++) begin
      step(0, (i == 6) ? 2 : 0, 32'h0, rd);
      if (i == 6) check("shadow0_midramp_readback", rd, 32'h0001_0003);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (i == 3)  check("ramp_ch0_at_3", 32'(out_port[4:0]), 32'd0);
      if (i == 4)  check("ramp_ch0_at_4", 32'(out_port[4:0]), 32'd1);
      if (i == 8)  check("ramp_ch0_at_8", 32'(out_port[4:0]), 32'd2);
      if (i == 12) check("ramp_ch0_at_12", 32'(out_port[4:0]), 32'd3);
    end
    check("ramp_busy_cycles", 32'(busy_cnt), 32'd12);
    check("ramp_done_pulses", 32'(done_cnt), 32'd1);

    // Retarget during a ramp: toward 10, then back to 2 once out reaches 6
    do_reset();
    step(1, 1, 32'd2, rd);
    step(1, 2, 32'd10, rd);
    step(1, 0, 32'h3, rd);
    done_cnt = int'(done);
    guard = 0;
    while (out_port[4:0] != 5'd6 && guard < 60) begin
      step(0, 0, 32'h0, rd);
      done_cnt += int'(done);
      guard++;
    end
    check("retarget_reached_6", 32'(out_port[4:0]), 32'd6);
    step(1, 2, 32'd2, rd);
    done_cnt += int'(done);
    step(1, 0, 32'h3, rd);
    done_cnt += int'(done);
    prev = int'(out_port[4:0]);
    rose = 0;
    guard = 0;
    while (busy && guard < 60) begin
      step(0, 0, 32'h0, rd);
      done_cnt += int'(done);
      if (int'(out_port[4:0]) > prev) rose = 1;
      prev = int'(out_port[4:0]);
      guard++;
    end
    check("retarget_final_ch0", 32'(out_port[4:0]), 32'd2);
    check("retarget_monotonic_down", 32'(rose), 32'd0);
    check("retarget_done_pulses", 32'(done_cnt), 32'd1);

    // RAMP_EN cleared mid-ramp: outputs snap one cycle later, done follows
    do_reset();
    step(1, 1, 32'd3, rd);
    step(1, 2, 32'd20, rd);
    step(1, 3, 32'd9, rd);
    step(1, 0, 32'h3, rd);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, rd);
    step(1, 0, 32'h0, rd);
    check("snap_still_busy", 32'(busy), 32'd1);
    step(0, 0, 32'h0, rd);
    check("snap_out_port", 32'(out_port), 32'h134);
    check("snap_done", 32'(done), 32'd1);
    step(0, 0, 32'h0, rd);
    check("snap_done_single", 32'(done), 32'd0);

    // Reset asserted mid-ramp: immediate return to reset values, no done
    do_reset();
    step(1, 2, 32'd15, rd);
    step(1, 0, 32'h3, rd);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, rd);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out_port", 32'(out_port), 32'h0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 32'h0, rd);

    // Randomized bus traffic against the model
    do_reset();
    for (int i = 0; i < 900; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        step(0, int'($urandom_range(0, 7)), $urandom, rd);
      end else if (r < 57) begin
        logic [31:0] cd;
        cd = '0;
        cd[0] = ($urandom_range(0, 9) < 7);
        cd[1] = ($urandom_range(0, 9) < 6);
        step(1, 0, cd, rd);
      end else if (r < 63) begin
        step(1, 1, 32'($urandom_range(0, 4)), rd);
      end else if (r < 92) begin
        step(1, int'($urandom_range(2, 3)), $urandom, rd);
      end else begin
        step(1, int'($urandom_range(4, 7)), $urandom, rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
